// File: rtl/counter_pkg.sv
// Shared constants for the programmable counter family: mode/direction encodings
// and default widths.
package counter_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_PRE_W = 16;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;

endpackage

// File: rtl/tick_prescaler.sv
// Enable-gated prescaler: emits a one-cycle tick every prescale+1 enabled cycles.
// tick is combinational so the consumer can act on the same edge.
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sync_clr,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  logic [PRE_W-1:0] cnt;

  assign tick = enable && !sync_clr && (cnt == prescale);

  // A count above a freshly lowered prescale falls back to 0 without ticking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (sync_clr) begin
      cnt <= '0;
    end else if (enable) begin
      if (cnt >= prescale) cnt <= '0;
      else                 cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with modulus, wrap or saturate behaviour and a
// prescaled step rate; all outputs are registered.
module prog_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             up_down,
  input  logic             mode,
  input  logic [WIDTH-1:0] modulus,
  input  logic [PRE_W-1:0] prescale,
  output logic [WIDTH-1:0] counter_out,
  output logic             step,
  output logic             tc,
  output logic             sat
);

  logic             tick;
  logic             sat_up;
  logic [WIDTH-1:0] cnt_nx;
  logic             step_nx;
  logic             tc_nx;
  logic             sat_nx;
  logic             sat_up_nx;

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v,
                                                  input logic [WIDTH-1:0] m);
    return (v > m) ? m : v;
  endfunction

  // Saturation persists only while the next step would still push into the boundary.
  function automatic logic sat_holds(input logic             s,
                                     input logic             md,
                                     input logic             dir,
                                     input logic [WIDTH-1:0] c,
                                     input logic [WIDTH-1:0] m);
    logic at_edge;
    at_edge = (dir == DIR_UP) ? (c >= m) : (c == '0);
    return s && (md == MODE_SAT) && at_edge;
  endfunction

  tick_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk      (CLOCK_50),
    .rst_n    (RESET_N),
    .enable   (enable),
    .sync_clr (clear | load),
    .prescale (prescale),
    .tick     (tick)
  );

  always_comb begin
    cnt_nx    = counter_out;
    step_nx   = 1'b0;
    tc_nx     = 1'b0;
    sat_nx    = sat;
    sat_up_nx = sat_up;
    if (clear) begin
      cnt_nx = '0;
      sat_nx = 1'b0;
    end else if (load) begin
      cnt_nx = clamp_load(load_value, modulus);
      sat_nx = 1'b0;
    end else if (tick) begin
      step_nx = 1'b1;
      sat_nx  = 1'b0;
      if (up_down == DIR_UP) begin
        if (counter_out < modulus) begin
          cnt_nx = counter_out + 1'b1;
          if (mode == MODE_SAT && cnt_nx == modulus) begin
            sat_nx    = 1'b1;
            sat_up_nx = DIR_UP;
            tc_nx     = 1'b1;
          end
        end else if (mode == MODE_WRAP) begin
          cnt_nx = '0;
          tc_nx  = 1'b1;
        end else begin
          cnt_nx    = modulus;
          sat_nx    = 1'b1;
          sat_up_nx = DIR_UP;
          tc_nx     = !(sat && sat_up == DIR_UP);
        end
      end else begin
        // Modulus lowered below the count: snap to the new top, no terminal event.
        if (counter_out > modulus) begin
          cnt_nx    = modulus;
          sat_nx    = (mode == MODE_SAT) && (modulus == '0);
          sat_up_nx = DIR_DOWN;
        end else if (counter_out != '0) begin
          cnt_nx = counter_out - 1'b1;
          if (mode == MODE_SAT && cnt_nx == '0) begin
            sat_nx    = 1'b1;
            sat_up_nx = DIR_DOWN;
            tc_nx     = 1'b1;
          end
        end else if (mode == MODE_WRAP) begin
          cnt_nx = modulus;
          tc_nx  = 1'b1;
        end else begin
          cnt_nx    = '0;
          sat_nx    = 1'b1;
          sat_up_nx = DIR_DOWN;
          tc_nx     = !(sat && sat_up == DIR_DOWN);
        end
      end
    end else begin
      sat_nx = sat_holds(sat, mode, up_down, counter_out, modulus);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      counter_out <= '0;
      step        <= 1'b0;
      tc          <= 1'b0;
      sat         <= 1'b0;
      sat_up      <= DIR_UP;
    end else begin
      counter_out <= cnt_nx;
      step        <= step_nx;
      tc          <= tc_nx;
      sat         <= sat_nx;
      sat_up      <= sat_up_nx;
    end
  end

endmodule
